// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage LC-3b pipeline: register load enables,
// ID/EX bubble and IF/ID squash, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 icache_resp,
    input  logic                 dcache_req,
    input  logic                 dcache_resp,
    input  logic                 branch_taken,
    input  logic [2:0]           id_sr1_num,
    input  logic [2:0]           id_sr2_num,
    input  logic                 id_uses_sr1,
    input  logic                 id_uses_sr2,
    input  logic [2:0]           id_ex_dest,
    input  logic                 id_ex_is_load,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 bubble_id_ex,
    output logic                 flush_if_id,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_fcnt;
    logic [2:0]           w_fcnt_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic                 w_count_stall;
    logic                 w_mem_stall;
    logic                 w_lu_hazard;
    logic                 w_sr1_match;
    logic                 w_sr2_match;

    // Hazard detection: any cache wait freezes the whole pipe; a load in EX
    // feeding the ID instruction needs one bubble.
    assign w_mem_stall = (dcache_req & ~dcache_resp) | ~icache_resp;
    assign w_sr1_match = id_uses_sr1 & (id_sr1_num == id_ex_dest);
    assign w_sr2_match = id_uses_sr2 & (id_sr2_num == id_ex_dest);
    assign w_lu_hazard = id_ex_is_load & (w_sr1_match | w_sr2_match);

    // State, flush counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_fcnt         <= 3'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_count_stall && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
        end
    end

    // Next-state and output decode, in priority order.
    always_comb begin
        w_state_nxt   = r_state;
        w_fcnt_nxt    = r_fcnt;
        w_count_stall = 1'b0;
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        bubble_id_ex  = 1'b0;
        flush_if_id   = 1'b0;

        if (reset) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            bubble_id_ex = 1'b1;
            flush_if_id  = 1'b1;
            w_state_nxt  = ST_RUN;
            w_fcnt_nxt   = 3'd0;
        end else if (w_mem_stall) begin
            // Branch and hazard sources are frozen too; they re-evaluate later.
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            load_ex_mem   = 1'b0;
            load_mem_wb   = 1'b0;
            w_count_stall = 1'b1;
        end else if (branch_taken) begin
            bubble_id_ex = 1'b1;
            flush_if_id  = 1'b1;
            if (FLUSH_CYCLES > 32'd1) begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = FLUSH_RELOAD;
            end else begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = 3'd0;
            end
        end else if (r_state == ST_FLUSH) begin
            // ID holds a wrong-path instruction, so its hazards are irrelevant.
            bubble_id_ex = 1'b1;
            flush_if_id  = 1'b1;
            if (r_fcnt <= 3'd1) begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = 3'd0;
            end else begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = r_fcnt - 3'd1;
            end
        end else if (w_lu_hazard) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            bubble_id_ex  = 1'b1;
            w_count_stall = 1'b1;
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expected values.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_resp;
    logic        dcache_req;
    logic        dcache_resp;
    logic        branch_taken;
    logic [2:0]  id_sr1_num;
    logic [2:0]  id_sr2_num;
    logic        id_uses_sr1;
    logic        id_uses_sr2;
    logic [2:0]  id_ex_dest;
    logic        id_ex_is_load;
    logic        load_pc;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        bubble_id_ex;
    logic        flush_if_id;
    logic [15:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Output vector: {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush}
    localparam logic [6:0] O_RESET  = 7'b00000_11;
    localparam logic [6:0] O_NORMAL = 7'b11111_00;
    localparam logic [6:0] O_FREEZE = 7'b00000_00;
    localparam logic [6:0] O_FLUSH  = 7'b11111_11;
    localparam logic [6:0] O_LU     = 7'b00111_10;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .icache_resp  (icache_resp),
        .dcache_req   (dcache_req),
        .dcache_resp  (dcache_resp),
        .branch_taken (branch_taken),
        .id_sr1_num   (id_sr1_num),
        .id_sr2_num   (id_sr2_num),
        .id_uses_sr1  (id_uses_sr1),
        .id_uses_sr2  (id_uses_sr2),
        .id_ex_dest   (id_ex_dest),
        .id_ex_is_load(id_ex_is_load),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Sample combinational outputs at the falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk);
        obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        n_tests++;
        assert (stall_cycles === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, stall_cycles, exp);
        end
    endtask

    task automatic idle_inputs();
        icache_resp   = 1'b1;
        dcache_req    = 1'b0;
        dcache_resp   = 1'b0;
        branch_taken  = 1'b0;
        id_sr1_num    = 3'd0;
        id_sr2_num    = 3'd0;
        id_uses_sr1   = 1'b0;
        id_uses_sr2   = 1'b0;
        id_ex_dest    = 3'd0;
        id_ex_is_load = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        cyc("reset_out0", O_RESET);
        cyc("reset_out1", O_RESET);
        chk_cnt("reset_cnt", 16'd0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc("run_idle", O_NORMAL);
        chk_cnt("run_idle_cnt", 16'd0);

        // Load-use via SR2
        id_ex_is_load = 1'b1; id_ex_dest = 3'd3; id_uses_sr2 = 1'b1; id_sr2_num = 3'd3;
        cyc("lu_sr2", O_LU);
        chk_cnt("lu_sr2_cnt", 16'd1);
        id_ex_is_load = 1'b0;
        cyc("lu_after", O_NORMAL);
        chk_cnt("lu_after_cnt", 16'd1);

        // R0 matches like any register; an unused source does not
        idle_inputs();
        id_ex_is_load = 1'b1; id_ex_dest = 3'd0; id_sr1_num = 3'd0;
        cyc("lu_unused_src", O_NORMAL);
        id_uses_sr1 = 1'b1;
        cyc("lu_r0", O_LU);
        chk_cnt("lu_r0_cnt", 16'd2);
        id_sr1_num = 3'd5;
        cyc("lu_nomatch", O_NORMAL);
        idle_inputs();

        // Plain taken branch: two squash cycles then RUN
        branch_taken = 1'b1;
        cyc("br_cycle", O_FLUSH);
        branch_taken = 1'b0;
        cyc("br_flush1", O_FLUSH);
        cyc("br_run", O_NORMAL);
        chk_cnt("br_cnt", 16'd2);

        // Data miss with pending branch: frozen 4 cycles, then branch resolves
        dcache_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) cyc("dmiss_freeze", O_FREEZE);
        chk_cnt("dmiss_cnt", 16'd6);
        dcache_resp = 1'b1;
        cyc("dmiss_br", O_FLUSH);
        chk_cnt("dmiss_br_cnt", 16'd6);
        idle_inputs();

        // Fetch miss during FLUSH: frozen, then one flush cycle remains
        icache_resp = 1'b0;
        for (int i = 0; i < 3; i++) cyc("imiss_freeze", O_FREEZE);
        chk_cnt("imiss_cnt", 16'd9);
        icache_resp = 1'b1;
        id_ex_is_load = 1'b1; id_ex_dest = 3'd2; id_uses_sr1 = 1'b1; id_sr1_num = 3'd2;
        cyc("flush_ignores_lu", O_FLUSH);
        chk_cnt("flush_lu_cnt", 16'd9);
        idle_inputs();
        cyc("flush_done", O_NORMAL);

        // Branch inside FLUSH reloads the counter
        branch_taken = 1'b1;
        cyc("rebr_0", O_FLUSH);
        cyc("rebr_1", O_FLUSH);
        branch_taken = 1'b0;
        cyc("rebr_2", O_FLUSH);
        cyc("rebr_run", O_NORMAL);

        // Reset mid-flush returns straight to RUN
        branch_taken = 1'b1;
        cyc("rst_flush_br", O_FLUSH);
        branch_taken = 1'b0; reset = 1'b1;
        cyc("rst_flush_out", O_RESET);
        reset = 1'b0;
        cyc("rst_flush_run", O_NORMAL);
        chk_cnt("rst_flush_cnt", 16'd0);

        // Saturation: 2^16+3 frozen cycles
        icache_resp = 1'b0;
        for (int i = 0; i < 65539; i++) @(posedge clk);
        #1;
        chk_cnt("sat_cnt", 16'hFFFF);
        cyc("sat_freeze", O_FREEZE);
        chk_cnt("sat_hold", 16'hFFFF);

        // Reset mid-stall
        reset = 1'b1;
        cyc("rst_stall_out", O_RESET);
        chk_cnt("rst_stall_cnt", 16'd0);
        reset = 1'b0; icache_resp = 1'b1;
        cyc("rst_stall_run", O_NORMAL);
        chk_cnt("rst_stall_cnt2", 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage LC-3b pipeline.
- Generates the load enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates the ID/EX bubble select (the zero-control mux select) and the IF/ID squash.
- Resolves cache-miss freezes, load-use stalls and taken-branch flushes, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- FLUSH_CYCLES, 2: number of consecutive cycles IF/ID is squashed after a taken branch/jump/trap (1..7).
- CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- icache_resp  input  1  instruction fetch completed this cycle.
- dcache_req  input  1  MEM-stage instruction is accessing data memory.
- dcache_resp  input  1  data access completed this cycle.
- branch_taken  input  1  control transfer resolved taken (PC mux select nonzero).
- id_sr1_num  input  3  SR1 number of the instruction in ID.
- id_sr2_num  input  3  SR2 number of the instruction in ID.
- id_uses_sr1  input  1  ID instruction reads SR1.
- id_uses_sr2  input  1  ID instruction reads SR2.
- id_ex_dest  input  3  destination register of the instruction in EX.
- id_ex_is_load  input  1  EX instruction is LDR/LDB/LDI.
- load_pc  output  1  PC register enable.
- load_if_id  output  1  IF/ID register enable.
- load_id_ex  output  1  ID/EX register enable.
- load_ex_mem  output  1  EX/MEM register enable.
- load_mem_wb  output  1  MEM/WB register enable.
- bubble_id_ex  output  1  1 = ID/EX captures an all-zero control word and dest 0.
- flush_if_id  output  1  1 = IF/ID captures a NOP.
- stall_cycles  output  CNT_WIDTH  count of frozen or stalled cycles since reset, saturating.

Behaviour:
- State register: RUN, FLUSH. Flush counter fcnt is 3 bits.
- Outputs are combinational from state, fcnt and the current inputs.
- Condition mem_stall = (dcache_req & ~dcache_resp) | ~icache_resp.
- Condition lu_hazard = id_ex_is_load & ((id_uses_sr1 & id_sr1_num==id_ex_dest) | (id_uses_sr2 & id_sr2_num==id_ex_dest)).
- Reset (reset=1 at the edge):
  - state<=RUN, fcnt<=0, stall_cycles<=0.
  - While reset is high, all load_* = 0, bubble_id_ex=1, flush_if_id=1.
  - Reset mid-stall or mid-flush abandons that operation immediately.
- Priority 1, mem_stall:
  - All five load_* = 0, bubble_id_ex=0, flush_if_id=0.
  - state and fcnt hold.
  - stall_cycles increments.
  - branch_taken and lu_hazard are ignored. Their sources are frozen, so they are re-evaluated when the stall clears.
- Priority 2, branch_taken (no mem_stall):
  - All load_* = 1, bubble_id_ex=1, flush_if_id=1.
  - state<=FLUSH, fcnt<=FLUSH_CYCLES-1.
  - If FLUSH_CYCLES==1, state stays RUN.
  - A branch_taken arriving while already in FLUSH reloads fcnt.
- Priority 3, state FLUSH (no mem_stall, no branch):
  - All load_* = 1, flush_if_id=1, bubble_id_ex=1. The ID instruction is on the wrong path, so lu_hazard is ignored.
  - fcnt decrements; when fcnt==1 at the edge, next state is RUN.
- Priority 4, lu_hazard in RUN:
  - load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, load_ex_mem=1, load_mem_wb=1, flush_if_id=0.
  - stall_cycles increments.
  - Exactly one bubble per load-use pair: next cycle the load is in MEM, so lu_hazard deasserts.
- Otherwise (RUN, no events): all load_* = 1, bubble_id_ex=0, flush_if_id=0.
- stall_cycles saturates at all-ones and never wraps.
- Register R0 is not special; dest 0 matches sr 0.

Test Plan:
- Reset, then icache_resp=1, no events for 5 cycles -> all load_*=1, bubble=0, flush=0, stall_cycles=0.
- id_ex_is_load=1, id_ex_dest=3, id_uses_sr2=1, id_sr2_num=3 for one cycle -> load_pc=load_if_id=0, bubble_id_ex=1, load_id_ex=1; next cycle (is_load=0) normal; stall_cycles=1.
- branch_taken=1 for 1 cycle with FLUSH_CYCLES=2 -> flush_if_id=1 and bubble_id_ex=1 for exactly 2 cycles, then RUN.
- dcache_req=1, dcache_resp=0 for 4 cycles while branch_taken=1 -> all load_*=0 for 4 cycles, stall_cycles=4; resp cycle -> flush sequence starts.
- Assert icache_resp=0 during FLUSH cycle 1 for 3 cycles -> loads frozen, fcnt holds; flush resumes with 1 remaining cycle.
- Drive mem_stall continuously for 2^16+3 cycles with CNT_WIDTH=16 -> stall_cycles=16'hFFFF. Assert reset mid-stall -> stall_cycles=0, state RUN next cycle.
